// File: rtl/id_mcyc_seq_pkg.sv
// rtl/id_mcyc_seq_pkg.sv - shared constants and Thumb block-transfer decode for id_mcyc_seq
package id_mcyc_seq_pkg;

   localparam logic [2:0] RN_SEL_RN    = 3'b100;
   localparam logic [2:0] RM_SEL_NONE  = 3'b000;
   localparam logic [6:0] IMM_SEL_NONE = 7'b0000000;
   localparam logic [4:0] SHT_SEL_NONE = 5'b00000;

   localparam logic [3:0] OP_PUSHPOP     = 4'b1011;
   localparam logic [1:0] OP_PUSHPOP_SUB = 2'b10;
   localparam logic [3:0] OP_LDMSTM      = 4'b1100;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   typedef struct packed {
      logic       pushpop;
      logic       ldmstm;
      logic       load;
      logic       wb_ok;
      logic [8:0] rlist;
   } blk_dec_t;

   function automatic blk_dec_t decode_blk(input logic [15:0] inst);
      blk_dec_t   d;
      logic [7:0] lo8;
      lo8       = inst[7:0];
      d.pushpop = (inst[15:12] == OP_PUSHPOP) && (inst[10:9] == OP_PUSHPOP_SUB);
      d.ldmstm  = (inst[15:12] == OP_LDMSTM);
      d.load    = inst[11];
      d.rlist   = {d.pushpop & inst[8], lo8};
      // LDMIA with the base in the list loads the base; the loaded value wins
      d.wb_ok   = d.pushpop | ~inst[11] | ~lo8[inst[10:8]];
      return d;
   endfunction

endpackage

// File: rtl/id_rlist_pri.sv
// rtl/id_rlist_pri.sv - lowest-set-bit priority encoder and popcount over a 9-bit register list
module id_rlist_pri (
   input  logic [8:0] rlist,
   output logic [3:0] low_idx,
   output logic [8:0] low_onehot,
   output logic [3:0] count
);

   always_comb begin
      low_idx = 4'd0;
      count   = 4'd0;
      for (int i = 8; i >= 0; i--) begin
         if (rlist[i]) low_idx = 4'(i);
      end
      for (int i = 0; i < 9; i++) begin
         count = count + {3'b000, rlist[i]};
      end
   end

   assign low_onehot = rlist & (~rlist + 9'd1);

endmodule

// File: rtl/id_mcyc_seq.sv
// rtl/id_mcyc_seq.sv - ID-stage multi-cycle sequencer for PUSH/POP/LDMIA/STMIA
module id_mcyc_seq
   import id_mcyc_seq_pkg::*;
#(
   parameter int WORD_BYTES = 4,
   parameter int SP_IDX     = 13,
   parameter int LR_IDX     = 14,
   parameter int PC_IDX     = 15
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] INST,
   input  logic        INST_VALID,
   input  logic        EX_READY,
   input  logic        FLUSH,
   input  logic [2:0]  DEC_RN_SEL,
   input  logic [2:0]  DEC_RM_SEL,
   input  logic [6:0]  DEC_IMM_SEL,
   input  logic [4:0]  DEC_SHT_SEL,
   output logic [2:0]  RN_SEL_DP,
   output logic [2:0]  RM_SEL_DP,
   output logic [6:0]  IMM_SEL_DP,
   output logic [4:0]  SHT_SEL_DP,
   output logic        STALL_IF,
   output logic        BEAT_VALID,
   output logic        BEAT_LOAD,
   output logic        BEAT_LAST,
   output logic [3:0]  XFER_REG,
   output logic [5:0]  XFER_OFS,
   output logic [3:0]  BASE_REG,
   output logic        BASE_DIR,
   output logic [5:0]  BASE_DELTA,
   output logic        WB_EN,
   output logic        PC_LOAD,
   output logic        ILLEGAL
);

   logic [0:0] state;
   logic [8:0] rlist;
   logic [3:0] beat_idx;
   logic       ld;
   logic       pp;
   logic [3:0] base_reg;
   logic       base_dir;
   logic [5:0] base_delta;
   logic       wb_ok;
   logic       illegal;

   blk_dec_t   dec;
   logic       busy;
   logic       dec_hit;
   logic [8:0] pri_in;
   logic [3:0] pri_idx;
   logic [8:0] pri_onehot;
   logic [3:0] pri_cnt;

   assign dec     = decode_blk(INST);
   assign busy    = (state == ST_BUSY);
   assign dec_hit = !busy && INST_VALID && !FLUSH && (dec.pushpop || dec.ldmstm);

   // Idle: size the incoming list. Busy: walk the remaining list.
   assign pri_in = busy ? rlist : dec.rlist;

   id_rlist_pri u_pri (
      .rlist      (pri_in),
      .low_idx    (pri_idx),
      .low_onehot (pri_onehot),
      .count      (pri_cnt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         rlist      <= '0;
         beat_idx   <= '0;
         ld         <= 1'b0;
         pp         <= 1'b0;
         base_reg   <= '0;
         base_dir   <= 1'b0;
         base_delta <= '0;
         wb_ok      <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         illegal <= dec_hit && (pri_cnt == 4'd0);
         case (state)
            ST_IDLE: begin
               if (dec_hit && (pri_cnt != 4'd0)) begin
                  state      <= ST_BUSY;
                  rlist      <= dec.rlist;
                  beat_idx   <= '0;
                  ld         <= dec.load;
                  pp         <= dec.pushpop;
                  base_reg   <= dec.pushpop ? 4'(SP_IDX) : {1'b0, INST[10:8]};
                  base_dir   <= dec.pushpop & ~dec.load;
                  base_delta <= 6'(32'(pri_cnt) * WORD_BYTES);
                  wb_ok      <= dec.wb_ok;
               end
            end
            default: begin
               if (FLUSH) begin
                  state <= ST_IDLE;
                  rlist <= '0;
               end else if (EX_READY) begin
                  rlist    <= rlist & ~pri_onehot;
                  beat_idx <= beat_idx + 4'd1;
                  if (pri_cnt == 4'd1) state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign STALL_IF   = busy;
   assign BEAT_VALID = busy;
   assign BEAT_LOAD  = busy & ld;
   assign BEAT_LAST  = busy && (pri_cnt == 4'd1);
   assign XFER_REG   = !busy ? 4'd0 :
                       (pri_idx == 4'd8) ? (ld ? 4'(PC_IDX) : 4'(LR_IDX)) : pri_idx;
   assign XFER_OFS   = busy ? 6'(32'(beat_idx) * WORD_BYTES) : 6'd0;
   assign BASE_REG   = busy ? base_reg : 4'd0;
   assign BASE_DIR   = busy & base_dir;
   assign BASE_DELTA = busy ? base_delta : 6'd0;
   assign WB_EN      = BEAT_LAST & wb_ok;
   assign PC_LOAD    = busy && pp && ld && (pri_idx == 4'd8);
   assign ILLEGAL    = illegal;

   assign RN_SEL_DP  = busy ? RN_SEL_RN    : DEC_RN_SEL;
   assign RM_SEL_DP  = busy ? RM_SEL_NONE  : DEC_RM_SEL;
   assign IMM_SEL_DP = busy ? IMM_SEL_NONE : DEC_IMM_SEL;
   assign SHT_SEL_DP = busy ? SHT_SEL_NONE : DEC_SHT_SEL;

endmodule
